// File: rtl/sd2snes_mem_pkg.sv
// Shared constants and types for the sd2snes external memory controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default strobe cycle counts, the one-deep
// request latch types, and a byte-lane select helper.
package sd2snes_mem_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SNES_RD = 3'd1;
  localparam logic [2:0] ST_SNES_WR = 3'd2;
  localparam logic [2:0] ST_MCU_RD  = 3'd3;
  localparam logic [2:0] ST_MCU_WR  = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;

  // Default strobe lengths in CLK cycles (legal range 2..15)
  localparam int DEF_READ_CYCLES  = 4;
  localparam int DEF_WRITE_CYCLES = 4;

  // Width of the cycle down-counter; holds up to 15
  localparam int TIMER_W = 4;

  // One-deep pending read request: valid flag plus latched byte address
  typedef struct packed {
    logic        vld;
    logic [23:0] addr;
  } rd_req_t;

  // One-deep pending write request: valid flag, byte address, write byte
  typedef struct packed {
    logic        vld;
    logic [23:0] addr;
    logic [7:0]  dat;
  } wr_req_t;

  // Pick the addressed byte lane of a 16-bit ROM word
  function automatic logic [7:0] byte_sel(input logic [15:0] dq, input logic hi);
    return hi ? dq[15:8] : dq[7:0];
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Cycle down-counter used to time ROM strobe lengths.
// Latency: load takes effect on the next edge; done is combinational on the count.
// Backpressure: none; dec is ignored once the count has reached zero.
//
// Ports: CLK, RST_N (async active-low); load/load_val preset the count;
// dec steps it down by one; done is high while the count is zero.
module mem_wait_timer
  import sd2snes_mem_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               done
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rom_ctrl.sv
// Arbitrates SNES and MCU byte accesses onto a 16-bit asynchronous SRAM/ROM bus.
// Latency: request pulse to read data = READ_CYCLES+1 clocks from an idle bus.
// Backpressure: none on SNES; each request kind is one-deep, a repeat pulse overwrites; MCU_RDY shows MCU busy.
//
// Ports: CLK, RST_N (async active-low); SNES_RD_REQ/SNES_WR_REQ with SNES_MADDR,
// SNES_WRITABLE, SNES_DIN and read result SNES_DOUT; MCU_RRQ/MCU_WRQ with
// MCU_ADDR, MCU_DOUT and read result MCU_DIN, MCU_RDY; ROM_A word address,
// ROM_DQ_IN/ROM_DQ_OUT/ROM_DQ_OE data bus, active-low ROM strobes; DROP_CNT
// counts SNES writes discarded because the target was not writable.
module rom_ctrl
  import sd2snes_mem_pkg::*;
#(
  parameter int READ_CYCLES  = DEF_READ_CYCLES,
  parameter int WRITE_CYCLES = DEF_WRITE_CYCLES
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SNES_RD_REQ,
  input  logic        SNES_WR_REQ,
  input  logic [23:0] SNES_MADDR,
  input  logic        SNES_WRITABLE,
  input  logic [7:0]  SNES_DIN,
  output logic [7:0]  SNES_DOUT,
  input  logic        MCU_RRQ,
  input  logic        MCU_WRQ,
  input  logic [23:0] MCU_ADDR,
  input  logic [7:0]  MCU_DOUT,
  output logic [7:0]  MCU_DIN,
  output logic        MCU_RDY,
  output logic [22:0] ROM_A,
  input  logic [15:0] ROM_DQ_IN,
  output logic [15:0] ROM_DQ_OUT,
  output logic        ROM_DQ_OE,
  output logic        ROM_CE_N,
  output logic        ROM_OE_N,
  output logic        ROM_WE_N,
  output logic        ROM_BHE_N,
  output logic        ROM_BLE_N,
  output logic [7:0]  DROP_CNT
);

  // Reads count down READ_CYCLES-1..0, one OE_N-low cycle per count.
  // Writes count down WRITE_CYCLES..0: the first cycle is data setup with
  // WE_N still high, the remaining WRITE_CYCLES cycles have WE_N low.
  localparam logic [TIMER_W-1:0] RD_LOAD = TIMER_W'(READ_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WR_LOAD = TIMER_W'(WRITE_CYCLES);

  logic [2:0] state;
  rd_req_t    srd_q, mrd_q;
  wr_req_t    swr_q, mwr_q;
  logic       swr_ok_q;      // writable flag captured with the SNES write
  logic       cur_hi_q;      // byte lane of the access in flight
  logic       cur_mcu_q;     // access in flight (or recovering) belongs to the MCU

  logic        clr_srd, clr_swr, clr_mrd, clr_mwr;
  logic        start_rd, start_wr, drop;
  logic [23:0] acc_addr;
  logic [7:0]  acc_dat;
  logic [2:0]  acc_state;
  logic        in_access;
  logic        timer_done;

  // Fixed-priority arbitration, only evaluated while the bus is idle
  always_comb begin
    clr_srd = 1'b0;
    clr_swr = 1'b0;
    clr_mrd = 1'b0;
    clr_mwr = 1'b0;
    if (state == ST_IDLE) begin
      if (srd_q.vld)      clr_srd = 1'b1;
      else if (swr_q.vld) clr_swr = 1'b1;
      else if (mrd_q.vld) clr_mrd = 1'b1;
      else if (mwr_q.vld) clr_mwr = 1'b1;
    end
  end

  // A non-writable SNES write is consumed here without touching the bus
  assign drop     = clr_swr && !swr_ok_q;
  assign start_rd = clr_srd || clr_mrd;
  assign start_wr = (clr_swr && swr_ok_q) || clr_mwr;

  always_comb begin
    acc_addr  = mwr_q.addr;
    acc_dat   = mwr_q.dat;
    acc_state = ST_MCU_WR;
    if (clr_srd) begin
      acc_addr  = srd_q.addr;
      acc_state = ST_SNES_RD;
    end else if (clr_swr) begin
      acc_addr  = swr_q.addr;
      acc_dat   = swr_q.dat;
      acc_state = ST_SNES_WR;
    end else if (clr_mrd) begin
      acc_addr  = mrd_q.addr;
      acc_state = ST_MCU_RD;
    end
  end

  assign in_access = (state == ST_SNES_RD) || (state == ST_MCU_RD) ||
                     (state == ST_SNES_WR) || (state == ST_MCU_WR);

  mem_wait_timer u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (start_rd || start_wr),
    .load_val (start_rd ? RD_LOAD : WR_LOAD),
    .dec      (in_access),
    .done     (timer_done)
  );

  // MCU is busy from the cycle after its pulse until the cycle after RECOVER
  assign MCU_RDY = !(mrd_q.vld || mwr_q.vld ||
                     (state == ST_MCU_RD) || (state == ST_MCU_WR) ||
                     ((state == ST_RECOVER) && cur_mcu_q));

  // Pending request latches. A new pulse wins over a same-edge clear so a
  // request arriving just as its predecessor is dispatched is never lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      srd_q    <= '0;
      swr_q    <= '0;
      mrd_q    <= '0;
      mwr_q    <= '0;
      swr_ok_q <= 1'b0;
    end else begin
      if (SNES_RD_REQ) begin
        srd_q.vld  <= 1'b1;
        srd_q.addr <= SNES_MADDR;
      end else if (clr_srd) begin
        srd_q.vld  <= 1'b0;
      end

      if (SNES_WR_REQ) begin
        swr_q.vld  <= 1'b1;
        swr_q.addr <= SNES_MADDR;
        swr_q.dat  <= SNES_DIN;
        swr_ok_q   <= SNES_WRITABLE;
      end else if (clr_swr) begin
        swr_q.vld  <= 1'b0;
      end

      if (MCU_RRQ) begin
        mrd_q.vld  <= 1'b1;
        mrd_q.addr <= MCU_ADDR;
      end else if (clr_mrd) begin
        mrd_q.vld  <= 1'b0;
      end

      if (MCU_WRQ) begin
        mwr_q.vld  <= 1'b1;
        mwr_q.addr <= MCU_ADDR;
        mwr_q.dat  <= MCU_DOUT;
      end else if (clr_mwr) begin
        mwr_q.vld  <= 1'b0;
      end
    end
  end

  // Bus FSM. All strobes are registered so they change only on CLK edges
  // and go inactive directly on reset assertion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      cur_hi_q   <= 1'b0;
      cur_mcu_q  <= 1'b0;
      SNES_DOUT  <= '0;
      MCU_DIN    <= '0;
      ROM_A      <= '0;
      ROM_DQ_OUT <= '0;
      ROM_DQ_OE  <= 1'b0;
      ROM_CE_N   <= 1'b1;
      ROM_OE_N   <= 1'b1;
      ROM_WE_N   <= 1'b1;
      ROM_BHE_N  <= 1'b1;
      ROM_BLE_N  <= 1'b1;
      DROP_CNT   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rd || start_wr) begin
            state     <= acc_state;
            ROM_A     <= acc_addr[23:1];
            cur_hi_q  <= acc_addr[0];
            cur_mcu_q <= clr_mrd || clr_mwr;
            ROM_CE_N  <= 1'b0;
            ROM_BHE_N <= !acc_addr[0];
            ROM_BLE_N <= acc_addr[0];
            if (start_rd) begin
              ROM_OE_N <= 1'b0;
            end else begin
              // Drive data one cycle ahead of WE_N for setup
              ROM_DQ_OUT <= {acc_dat, acc_dat};
              ROM_DQ_OE  <= 1'b1;
            end
          end
          if (drop && (DROP_CNT != 8'hFF)) begin
            DROP_CNT <= DROP_CNT + 8'd1;
          end
        end

        ST_SNES_RD, ST_MCU_RD: begin
          if (timer_done) begin
            if (state == ST_SNES_RD) SNES_DOUT <= byte_sel(ROM_DQ_IN, cur_hi_q);
            else                     MCU_DIN   <= byte_sel(ROM_DQ_IN, cur_hi_q);
            state     <= ST_RECOVER;
            ROM_CE_N  <= 1'b1;
            ROM_OE_N  <= 1'b1;
            ROM_BHE_N <= 1'b1;
            ROM_BLE_N <= 1'b1;
          end
        end

        ST_SNES_WR, ST_MCU_WR: begin
          if (timer_done) begin
            state     <= ST_RECOVER;
            ROM_CE_N  <= 1'b1;
            ROM_WE_N  <= 1'b1;
            ROM_BHE_N <= 1'b1;
            ROM_BLE_N <= 1'b1;
            ROM_DQ_OE <= 1'b0;
          end else begin
            ROM_WE_N  <= 1'b0;
          end
        end

        ST_RECOVER: begin
          state <= ST_IDLE;
        end

        default: begin
          state     <= ST_IDLE;
          ROM_CE_N  <= 1'b1;
          ROM_OE_N  <= 1'b1;
          ROM_WE_N  <= 1'b1;
          ROM_BHE_N <= 1'b1;
          ROM_BLE_N <= 1'b1;
          ROM_DQ_OE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_ctrl.md
ROM_CTRL -- requirements
Module: rom_ctrl

Interface
REQ-001 Parameter READ_CYCLES, default 4, clocks of OE_N low before read data capture (legal 2..15).
REQ-002 Parameter WRITE_CYCLES, default 4, clocks of WE_N low per write (legal 2..15).
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  in  1  reset; asynchronous assertion, active low.
REQ-005 SNES_RD_REQ / SNES_WR_REQ  in  1 each  one-cycle SNES access request pulses.
REQ-006 SNES_MADDR  in  24  mapped byte address from the address decoder.
REQ-007 SNES_WRITABLE  in  1  decoder writable flag, sampled with SNES_WR_REQ.
REQ-008 SNES_DIN  in  8  SNES write byte; SNES_DOUT  out  8  last SNES read byte.
REQ-009 MCU_RRQ / MCU_WRQ  in  1 each  MCU request pulses; MCU_ADDR  in  24; MCU_DOUT  in  8 (MCU write byte); MCU_DIN  out  8 (MCU read byte).
REQ-010 MCU_RDY  out  1  high when no MCU request is pending or executing.
REQ-011 ROM_A  out  23  word address (byte address bits 23:1).
REQ-012 ROM_DQ_IN  in  16; ROM_DQ_OUT  out  16; ROM_DQ_OE  out  1 (drive enable).
REQ-013 ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N  out  1 each  active-low SRAM strobes.
REQ-014 DROP_CNT  out  8  count of discarded SNES writes, saturating at 255.

Function
REQ-015 FSM states: IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR, RECOVER.
REQ-016 Each request pulse SHALL set a one-deep pending flag (SNES read, SNES write, MCU read, MCU write) with latched address/data; a new pulse of the same kind overwrites it.
REQ-017 In IDLE, arbitration priority SHALL be SNES read > SNES write > MCU read > MCU write; the selected flag clears on the transition.
REQ-018 SNES write pending with SNES_WRITABLE low at request time SHALL be discarded without bus activity and SHALL increment DROP_CNT.
REQ-019 On entering an access state, ROM_A, byte enables and ROM_CE_N low SHALL be asserted in that same cycle; byte address bit 0 = 0 selects low byte (BLE_N low), 1 selects high byte (BHE_N low).
REQ-020 Reads: ROM_OE_N low for READ_CYCLES clocks; on the last, the selected byte of ROM_DQ_IN SHALL load SNES_DOUT or MCU_DIN on the next edge.
REQ-021 Writes: ROM_DQ_OUT = {byte,byte}, ROM_DQ_OE high for WRITE_CYCLES+1 clocks; ROM_WE_N low for exactly WRITE_CYCLES clocks, starting one clock after DQ_OE (data setup).
REQ-022 After every access the FSM SHALL spend one RECOVER cycle (all strobes high, DQ_OE low) then return to IDLE; ROM_OE_N and ROM_WE_N SHALL never be low together.
REQ-023 Request pulses arriving in any state SHALL be latched, never lost; simultaneous SNES and MCU pulses in IDLE SHALL serve SNES first.
REQ-024 Read latency, request pulse to SNES_DOUT update, SHALL be READ_CYCLES+1 clocks from an idle bus.
REQ-025 MCU_RDY SHALL fall in the cycle after an MCU request pulse and rise in the cycle after that access's RECOVER.
REQ-026 In IDLE all strobes high, ROM_DQ_OE low, ROM_A holding last value.

Reset
REQ-027 RST_N low SHALL immediately force IDLE, clear pending flags and counters, ROM_CE_N/OE_N/WE_N/BHE_N/BLE_N high, ROM_DQ_OE low.
REQ-028 Reset values: SNES_DOUT 0, MCU_DIN 0, MCU_RDY 1, ROM_A 0, ROM_DQ_OUT 0, DROP_CNT 0; an access interrupted by reset is abandoned, not replayed.

Structure
REQ-029 FSM state encoding and default cycle constants SHALL live in shared package sd2snes_mem_pkg.
REQ-030 The cycle down-counter (load, decrement, terminal flag) SHALL be sub-module mem_wait_timer; remainder in rom_ctrl.

Verification
REQ-031 SNES_RD_REQ, MADDR 0x123457, ROM_DQ_IN 0xA55A -> ROM_A 0x091A2B, BHE_N low, SNES_DOUT 0xA5 five clocks after pulse.
REQ-032 SNES_WR_REQ, MADDR 0xE00010, DIN 0x3C, writable -> DQ_OUT 0x3C3C, BLE_N low, WE_N low exactly 4 clocks inside DQ_OE window.
REQ-033 SNES_WR_REQ with SNES_WRITABLE 0 -> no strobe activity, DROP_CNT 0->1; 300 such -> DROP_CNT 255.
REQ-034 MCU_RRQ and SNES_RD_REQ same cycle -> SNES read completes first, MCU read follows after RECOVER; MCU_RDY low throughout, high after.
REQ-035 RST_N low during WE_N-low cycle 2 -> WE_N, CE_N high and DQ_OE low in that cycle; after release no write replayed.
REQ-036 Continuous checker over all tests: OE_N and WE_N never both low; DQ_OE never high with OE_N low.
